// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative signed multiply / divide datapath for the multicycle CPU.
//   Control pulses a start, waits for done (or div_by_zero), then copies
//   hi/lo into the architectural HI/LO registers.
//
//   Multiply: radix-2 Booth, one step per cycle, WIDTH steps.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle,
//             followed by a sign-fix cycle (truncation toward zero).
//   Latency:  start accepted at edge E0 -> done high after edge E0+WIDTH+1.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_mult_i   1-cycle request: signed a*b (wins over start_div_i)
//   start_div_i    1-cycle request: signed a/b
//   a_i, b_i       operands, sampled only at the accepting edge
//   hi_o           mult: product high half; div: remainder
//   lo_o           mult: product low half;  div: quotient
//   busy_o         operation in progress
//   done_o         1-cycle pulse, hi/lo valid
//   div_by_zero_o  1-cycle pulse, divide with b==0 rejected
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_mult_i,
  input  logic             start_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared working register.
  //   Mult: {acc[W-1:0], multiplier[W-1:0], q_minus1}
  //   Div:  {rem[W:0], dividend/quotient[W-1:0]}
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // mult: a; div: |b|
  logic               is_div_q, is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     acc_ext, mc_ext, booth_sum;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   quo, rem;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    abs_a = a_i[WIDTH-1] ? -a_i : a_i;
    abs_b = b_i[WIDTH-1] ? -b_i : b_i;

    // Booth step: the add is done one bit wider than the accumulator so that
    // a most-negative multiplicand cannot overflow; the shift then takes the
    // true sign from the widened sum.
    acc_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    mc_ext  = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum = acc_ext + mc_ext;
      2'b10:   booth_sum = acc_ext - mc_ext;
      default: booth_sum = acc_ext;
    endcase

    // Restoring step: shift next dividend bit into the partial remainder and
    // try subtracting the divisor magnitude.
    rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};

    quo = prod_q[WIDTH-1:0];
    rem = prod_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start_mult_i) begin
          state_d  = S_MULT;
          cnt_d    = '0;
          busy_d   = 1'b1;
          is_div_d = 1'b0;
          mcand_d  = a_i;
          prod_d   = {{WIDTH{1'b0}}, b_i, 1'b0};
        end else if (start_div_i) begin
          if (b_i == '0) begin
            state_d = S_DONE;
            dbz_d   = 1'b1;
          end else begin
            state_d   = S_DIV;
            cnt_d     = '0;
            busy_d    = 1'b1;
            is_div_d  = 1'b1;
            neg_quo_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_rem_d = a_i[WIDTH-1];
            mcand_d   = abs_b;
            prod_d    = {{(WIDTH+1){1'b0}}, abs_a};
          end
        end
      end
      S_MULT: begin
        prod_d = {booth_sum, prod_q[WIDTH:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!rem_diff[WIDTH]) prod_d = {rem_diff, prod_q[WIDTH-2:0], 1'b1};
        else                  prod_d = {rem_sh, prod_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_quo_q ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          hi_d = prod_q[2*WIDTH:WIDTH+1];
          lo_d = prod_q[WIDTH:1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed vectors against a cycle-level behavioural model of
//   mult_div_unit; a compare process checks every output on every falling
//   edge, and each operation also pins latency and hi/lo to literals.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi_o, lo_o;
  logic         busy_o, done_o, dbz_o;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;
  int           m_remain = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_mult_i (start_mult),
    .start_div_i  (start_div),
    .a_i          (a),
    .b_i          (b),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(dbz_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a signed operation from plain 64-bit arithmetic.
  task automatic compute(input bit mul, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, r, q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (mul) begin
      r = sx * sy;
      h = r[63:32];
      l = r[31:0];
    end else begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end
  endtask

  always @(negedge rst_n) begin
    m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
    m_hi = '0; m_lo = '0; m_remain = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_busy) begin
        m_remain--;
        if (m_remain == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
        end
      end else if (start_mult) begin
        compute(1'b1, a, b, p_hi, p_lo);
        m_busy = 1'b1;
        m_remain = W + 1;
      end else if (start_div) begin
        if (b == '0) m_dbz = 1'b1;
        else begin
          compute(1'b0, a, b, p_hi, p_lo);
          m_busy = 1'b1;
          m_remain = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy_o}, {31'd0, m_busy});
    check("done", {31'd0, done_o}, {31'd0, m_done});
    check("div_by_zero", {31'd0, dbz_o}, {31'd0, m_dbz});
    check("hi", hi_o, m_hi);
    check("lo", lo_o, m_lo);
  end

  task automatic run_op(input string tag, input bit mul, input bit both,
                        input logic [31:0] x, input logic [31:0] y, input bit inject,
                        input logic [31:0] eh, input logic [31:0] el, input bit edbz);
    bit seen;
    int lat;
    @(negedge clk);
    start_mult = mul | both;
    start_div  = ~mul | both;
    a = x;
    b = y;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start_mult = 1'b0; start_div = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678;
      end
      if (inject && i == 9) begin start_mult = 1'b1; a = 32'd1000; b = 32'd1000; end
      if (inject && i == 10) start_mult = 1'b0;
      if (done_o || dbz_o) begin seen = 1'b1; lat = i; end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no done/div_by_zero within 40 cycles, expected one", tag);
    end else begin
      check({tag, " latency"}, 32'(lat), edbz ? 32'd0 : 32'(W + 1));
      check({tag, " dbz"}, {31'd0, dbz_o}, {31'd0, edbz});
      check({tag, " done"}, {31'd0, done_o}, {31'd0, ~edbz});
      check({tag, " hi"}, hi_o, eh);
      check({tag, " lo"}, lo_o, el);
      $display("op %-10s a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0d lat=%0d",
               tag, x, y, hi_o, lo_o, dbz_o, lat);
    end
  endtask

  initial begin
    #12;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset dbz", {31'd0, dbz_o}, 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul7x-3",   1, 0, 32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("div-7/2",   0, 0, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div7/-2",   0, 0, 32'd7,        32'hFFFFFFFE, 0, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op("div5/0",    0, 0, 32'd5,        32'd0,        0, 32'h00000001, 32'hFFFFFFFD, 1);
    run_op("mulmin2",   1, 0, 32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h00000000, 0);
    run_op("divmin/-1", 0, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h80000000, 0);
    run_op("mul-1x-1",  1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000000, 32'h00000001, 0);
    run_op("div100/7",  0, 0, 32'd100,      32'd7,        0, 32'h00000002, 32'h0000000E, 0);
    run_op("div-100/-7",0, 0, 32'hFFFFFF9C, 32'hFFFFFFF9, 0, 32'hFFFFFFFE, 32'h0000000E, 0);
    run_op("mulinject", 1, 0, 32'd123,      32'd456,      1, 32'h00000000, 32'h0000DB18, 0);
    run_op("both",      1, 1, 32'd100,      32'd7,        0, 32'h00000000, 32'h000002BC, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start_mult = 1'b1; a = 32'd9; b = 32'd9;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) start_mult = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy_o}, 32'd0);
    check("midreset done", {31'd0, done_o}, 32'd0);
    check("midreset dbz", {31'd0, dbz_o}, 32'd0);
    check("midreset hi", hi_o, 32'd0);
    check("midreset lo", lo_o, 32'd0);
    $display("op reset     asserted mid-multiply");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul-5x6",   1, 0, 32'hFFFFFFFB, 32'd6,        0, 32'hFFFFFFFF, 32'hFFFFFFE2, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
